// File: rtl/host_trans_status_pkg.sv
// Shared encodings for the host transaction status controller.
// The RETRY state only exists when HOST_NAK_RETRY_EN is defined.
package host_trans_status_pkg;

    localparam logic [1:0] TRANS_SETUP = 2'b00;
    localparam logic [1:0] TRANS_IN    = 2'b01;
    localparam logic [1:0] TRANS_OUT0  = 2'b10;
    localparam logic [1:0] TRANS_OUT1  = 2'b11;

    localparam int STAT_DATA_SEQ  = 7;
    localparam int STAT_ACK       = 6;
    localparam int STAT_STALL     = 5;
    localparam int STAT_NAK       = 4;
    localparam int STAT_TIMEOUT   = 3;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_BIT_STUFF = 1;
    localparam int STAT_CRC       = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
`ifdef HOST_NAK_RETRY_EN
        ST_RETRY  = 3'd4,
`endif
        ST_UPDATE = 3'd3
    } transState_t;

endpackage

// File: rtl/host_trans_status.sv
// Host-side transaction sequencer between the CPU and the SIE, with status capture.
// Optional automatic NAK retry is enabled by defining HOST_NAK_RETRY_EN.
//
// state  | meaning
// IDLE   | no transaction; transReq latches transType and starts one
// REQ    | sieTransReq high until the SIE acknowledges
// WAIT   | waiting for sieTransDone; status captured on that edge
// UPDATE | one-cycle transDoneInt, then back to IDLE
// RETRY  | (retry build) bump retryCnt and re-issue the same request
module host_trans_status
    import host_trans_status_pkg::*;
#(
    parameter logic [3:0] RETRY_LIMIT = 4'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       transReq,
    input  logic [1:0] transType,
    input  logic       clrStatus,
    output logic       sieTransReq,
    output logic [1:0] sieTransType,
    input  logic       sieTransAck,
    input  logic       sieTransDone,
    input  logic [7:0] sieStatus,
    output logic [7:0] statusReg,
    output logic       transBusy,
    output logic       transDoneInt,
    output logic [3:0] retryCnt
);

    transState_t state;
    transState_t stateNext;
    logic        capture;
    logic        startTrans;

    assign startTrans = (state == ST_IDLE) && transReq;
    assign capture    = (state == ST_WAIT) && sieTransDone;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (transReq) stateNext = ST_REQ;
            end
            ST_REQ: begin
                if (sieTransAck) stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                if (sieTransDone) begin
`ifdef HOST_NAK_RETRY_EN
                    if (sieStatus[STAT_NAK] && (retryCnt < RETRY_LIMIT)) begin
                        stateNext = ST_RETRY;
                    end else begin
                        stateNext = ST_UPDATE;
                    end
`else
                    stateNext = ST_UPDATE;
`endif
                end
            end
            ST_UPDATE: begin
                stateNext = ST_IDLE;
            end
`ifdef HOST_NAK_RETRY_EN
            ST_RETRY: begin
                stateNext = ST_REQ;
            end
`endif
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sieTransType <= TRANS_SETUP;
        end else if (startTrans) begin
            sieTransType <= transType;
        end
    end

    // A capture wins over a simultaneous CPU clear so a fresh result is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statusReg <= 8'h00;
        end else if (capture) begin
            statusReg <= sieStatus;
        end else if (clrStatus) begin
            statusReg <= 8'h00;
        end
    end

`ifdef HOST_NAK_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retryCnt <= 4'd0;
        end else if (startTrans) begin
            retryCnt <= 4'd0;
        end else if (state == ST_RETRY) begin
            retryCnt <= retryCnt + 4'd1;
        end
    end
`else
    logic unusedRetryLimit;
    assign unusedRetryLimit = ^RETRY_LIMIT;
    assign retryCnt         = 4'd0;
`endif

    // Outputs decode the state register only, so no input reaches them combinationally.
    assign sieTransReq  = (state == ST_REQ);
    assign transBusy    = (state != ST_IDLE);
    assign transDoneInt = (state == ST_UPDATE);

endmodule

// File: tb/tb_host_trans_status.sv
// Self-checking bench for host_trans_status: directed scenarios plus a randomized
// SIE agent checked against a transaction-level model (HOST_NAK_RETRY_EN aware).
module tb_host_trans_status;

`ifdef HOST_NAK_RETRY_EN
    localparam int LIMIT = 2;
`else
    localparam int LIMIT = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       transReq;
    logic [1:0] transType;
    logic       clrStatus;
    logic       sieTransReq;
    logic [1:0] sieTransType;
    logic       sieTransAck;
    logic       sieTransDone;
    logic [7:0] sieStatus;
    logic [7:0] statusReg;
    logic       transBusy;
    logic       transDoneInt;
    logic [3:0] retryCnt;

    int checks = 0;
    int errors = 0;

    host_trans_status #(
        .RETRY_LIMIT(4'(LIMIT == 0 ? 8 : LIMIT))
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .transReq(transReq),
        .transType(transType),
        .clrStatus(clrStatus),
        .sieTransReq(sieTransReq),
        .sieTransType(sieTransType),
        .sieTransAck(sieTransAck),
        .sieTransDone(sieTransDone),
        .sieStatus(sieStatus),
        .statusReg(statusReg),
        .transBusy(transBusy),
        .transDoneInt(transDoneInt),
        .retryCnt(retryCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic startTrans(input logic [1:0] t);
        transType = t;
        transReq  = 1'b1;
        step();
        transReq  = 1'b0;
        transType = 2'($urandom);
    endtask

    // SIE agent: waits for a request, acks after ackDelay, completes after doneDelay.
    task automatic sieServe(input logic [1:0] expType, input logic [7:0] status,
                            input int ackDelay, input int doneDelay);
        int n;
        n = 0;
        while (sieTransReq !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (sieTransReq !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: sieTransReq=%b after %0d cycles, expected 1", sieTransReq, n);
        end
        checks++;
        if (sieTransType !== expType) begin
            errors++;
            $display("FAIL req_type: sieTransType=%b expected %b", sieTransType, expType);
        end
        repeat (ackDelay) step();
        checks++;
        if (sieTransReq !== 1'b1) begin
            errors++;
            $display("FAIL req_hold: sieTransReq=%b expected 1 before ack", sieTransReq);
        end
        sieTransAck = 1'b1;
        step();
        sieTransAck = 1'b0;
        checks++;
        if (sieTransReq !== 1'b0) begin
            errors++;
            $display("FAIL req_drop: sieTransReq=%b expected 0 after ack", sieTransReq);
        end
        repeat (doneDelay) step();
        sieStatus    = status;
        sieTransDone = 1'b1;
        step();
        sieTransDone = 1'b0;
        sieStatus    = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        transReq = 0; transType = 0; clrStatus = 0;
        sieTransAck = 0; sieTransDone = 0; sieStatus = 0;
        #3;
        checks++;
        if ({sieTransReq, sieTransType, statusReg, transBusy, transDoneInt, retryCnt} !== 17'h0) begin
            errors++;
            $display("FAIL reset_values: req=%b type=%b status=%h busy=%b int=%b retry=%0d, expected all 0",
                     sieTransReq, sieTransType, statusReg, transBusy, transDoneInt, retryCnt);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (transBusy !== 1'b0 || sieTransReq !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b req=%b expected 0 0", transBusy, sieTransReq);
        end
    endtask

    task automatic test_basic();
        startTrans(2'b01);
        checks++;
        if (sieTransReq !== 1'b1 || sieTransType !== 2'b01 || transBusy !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: req=%b type=%b busy=%b expected 1 01 1", sieTransReq, sieTransType, transBusy);
        end
        sieServe(2'b01, 8'h40, 3, 2);
        checks++;
        if (statusReg !== 8'h40 || transDoneInt !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: status=%h int=%b expected 40 1", statusReg, transDoneInt);
        end
        step();
        checks++;
        if (transDoneInt !== 1'b0 || transBusy !== 1'b0) begin
            errors++;
            $display("FAIL basic_int_width: int=%b busy=%b expected 0 0", transDoneInt, transBusy);
        end
    endtask

    task automatic test_clr_precedence();
        startTrans(2'b00);
        sieTransAck = 1'b1;
        step();
        sieTransAck = 1'b0;
        sieStatus    = 8'h01;
        sieTransDone = 1'b1;
        clrStatus    = 1'b1;
        step();
        sieTransDone = 1'b0;
        clrStatus    = 1'b0;
        checks++;
        if (statusReg !== 8'h01) begin
            errors++;
            $display("FAIL clr_vs_capture: status=%h expected 01", statusReg);
        end
        step();
        clrStatus = 1'b1;
        step();
        clrStatus = 1'b0;
        checks++;
        if (statusReg !== 8'h00) begin
            errors++;
            $display("FAIL clr_alone: status=%h expected 00", statusReg);
        end
    endtask

    task automatic test_ignore_req_in_wait();
        int ints;
        startTrans(2'b10);
        sieTransAck = 1'b1;
        step();
        sieTransAck = 1'b0;
        transReq  = 1'b1;
        transType = 2'b11;
        step();
        transReq = 1'b0;
        checks++;
        if (sieTransType !== 2'b10 || sieTransReq !== 1'b0) begin
            errors++;
            $display("FAIL wait_req_ignored: type=%b req=%b expected 10 0", sieTransType, sieTransReq);
        end
        sieStatus    = 8'h80;
        sieTransDone = 1'b1;
        ints = 0;
        step();
        sieTransDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (transDoneInt === 1'b1) ints++;
            step();
        end
        checks++;
        if (ints != 1 || sieTransType !== 2'b10 || transBusy !== 1'b0) begin
            errors++;
            $display("FAIL wait_single_int: ints=%0d type=%b busy=%b expected 1 10 0", ints, sieTransType, transBusy);
        end
    endtask

    // All-NAK SIE: retry build re-requests LIMIT times, plain build completes at once.
    task automatic test_nak();
        int reqs;
        startTrans(2'b11);
        reqs = 0;
        for (int a = 0; a <= LIMIT; a++) begin
            sieServe(2'b11, 8'h10, 0, 1);
            reqs++;
            if (a < LIMIT) begin
                checks++;
                if (transDoneInt !== 1'b0 || transBusy !== 1'b1) begin
                    errors++;
                    $display("FAIL nak_retry_noint: int=%b busy=%b expected 0 1", transDoneInt, transBusy);
                end
            end
        end
        checks++;
        if (transDoneInt !== 1'b1 || statusReg !== 8'h10 || retryCnt !== 4'(LIMIT) || reqs != LIMIT + 1) begin
            errors++;
            $display("FAIL nak_final: int=%b status=%h retry=%0d reqs=%0d expected 1 10 %0d %0d",
                     transDoneInt, statusReg, retryCnt, reqs, LIMIT, LIMIT + 1);
        end
        step();
        checks++;
        if (transBusy !== 1'b0 || transDoneInt !== 1'b0) begin
            errors++;
            $display("FAIL nak_idle: busy=%b int=%b expected 0 0", transBusy, transDoneInt);
        end
    endtask

    task automatic test_reset_mid();
        int ints;
        startTrans(2'b01);
        sieTransAck = 1'b1;
        step();
        sieTransAck = 1'b0;
        step();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({sieTransReq, sieTransType, statusReg, transBusy, transDoneInt, retryCnt} !== 17'h0) begin
            errors++;
            $display("FAIL reset_mid_async: req=%b type=%b status=%h busy=%b int=%b retry=%0d expected all 0",
                     sieTransReq, sieTransType, statusReg, transBusy, transDoneInt, retryCnt);
        end
        step();
        rst_n = 1'b1;
        sieStatus    = 8'h40;
        sieTransDone = 1'b1;
        step();
        sieTransDone = 1'b0;
        ints = 0;
        for (int i = 0; i < 4; i++) begin
            if (transDoneInt === 1'b1) ints++;
            step();
        end
        checks++;
        if (ints != 0 || statusReg !== 8'h00 || transBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: ints=%0d status=%h busy=%b expected 0 00 0", ints, statusReg, transBusy);
        end
    endtask

    task automatic test_done_in_idle();
        startTrans(2'b00);
        sieServe(2'b00, 8'h41, 1, 0);
        step();
        sieStatus    = 8'hAA;
        sieTransDone = 1'b1;
        sieTransAck  = 1'b1;
        step();
        sieTransDone = 1'b0;
        sieTransAck  = 1'b0;
        checks++;
        if (statusReg !== 8'h41 || transDoneInt !== 1'b0 || transBusy !== 1'b0 || sieTransReq !== 1'b0) begin
            errors++;
            $display("FAIL idle_done_ignored: status=%h int=%b busy=%b req=%b expected 41 0 0 0",
                     statusReg, transDoneInt, transBusy, sieTransReq);
        end
    endtask

    // Randomized transactions; model keeps expected status and retry count.
    task automatic test_random();
        logic [7:0] expStatus;
        logic [7:0] st;
        logic [1:0] t;
        int retries;
        bit done;
        expStatus = statusReg === 8'hxx ? 8'h00 : 8'h41;
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                clrStatus = 1'b1;
                step();
                clrStatus = 1'b0;
                expStatus = 8'h00;
                checks++;
                if (statusReg !== expStatus) begin
                    errors++;
                    $display("FAIL rand_clr: status=%h expected %h", statusReg, expStatus);
                end
            end
            t = 2'($urandom);
            startTrans(t);
            retries = 0;
            done = 0;
            while (!done) begin
                st = 8'($urandom);
                st[4] = ($urandom_range(0, 1) == 1);
                sieServe(t, st, $urandom_range(0, 4), $urandom_range(0, 4));
                expStatus = st;
                checks++;
                if (statusReg !== expStatus) begin
                    errors++;
                    $display("FAIL rand_capture: status=%h expected %h", statusReg, expStatus);
                end
                if (st[4] && retries < LIMIT) begin
                    retries++;
                    checks++;
                    if (transDoneInt !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_retry_int: int=%b expected 0", transDoneInt);
                    end
                    step();
                    checks++;
                    if (sieTransReq !== 1'b1 || retryCnt !== 4'(retries)) begin
                        errors++;
                        $display("FAIL rand_retry: req=%b retry=%0d expected 1 %0d", sieTransReq, retryCnt, retries);
                    end
                end else begin
                    checks++;
                    if (transDoneInt !== 1'b1 || retryCnt !== 4'(retries)) begin
                        errors++;
                        $display("FAIL rand_done: int=%b retry=%0d expected 1 %0d", transDoneInt, retryCnt, retries);
                    end
                    step();
                    checks++;
                    if (transDoneInt !== 1'b0 || transBusy !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_idle: int=%b busy=%b expected 0 0", transDoneInt, transBusy);
                    end
                    done = 1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clr_precedence();
        test_ignore_req_in_wait();
        test_nak();
        test_reset_mid();
        test_done_in_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/host_trans_status.md
HOST_TRANS_STATUS -- requirements
Module: host_trans_status

Interface
REQ-001 The parameter RETRY_LIMIT SHALL default to 4'd8 and set the maximum number of automatic NAK retries (used only when HOST_NAK_RETRY_EN is defined).
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; all flops on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-004 The port transReq SHALL be an input, 1 bit wide: CPU start pulse.
REQ-005 The port transType SHALL be an input, 2 bits wide: 00 SETUP, 01 IN, 10 OUTDATA0, 11 OUTDATA1.
REQ-006 The port clrStatus SHALL be an input, 1 bit wide: CPU clear pulse for statusReg.
REQ-007 The port sieTransReq SHALL be an output, 1 bit wide: transaction request to the SIE.
REQ-008 The port sieTransType SHALL be an output, 2 bits wide: latched transType presented to the SIE.
REQ-009 The port sieTransAck SHALL be an input, 1 bit wide: SIE accepted the request.
REQ-010 The port sieTransDone SHALL be an input, 1 bit wide: single-cycle SIE completion pulse.
REQ-011 The port sieStatus SHALL be an input, 8 bits wide: {dataSequence, ACKRxed, stallRxed, NAKRxed, RxTimeOut, RxOverflow, bitStuffError, CRCError}, valid on the sieTransDone cycle.
REQ-012 The port statusReg SHALL be an output, 8 bits wide: last captured status, same bit layout as sieStatus.
REQ-013 The port transBusy SHALL be an output, 1 bit wide: high in every state except IDLE.
REQ-014 The port transDoneInt SHALL be an output, 1 bit wide: single-cycle completion interrupt pulse.
REQ-015 The port retryCnt SHALL be an output, 4 bits wide: NAK retries performed for the current transaction.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT and UPDATE, plus RETRY when HOST_NAK_RETRY_EN is defined.
REQ-017 In IDLE, transReq=1 SHALL latch transType into sieTransType, clear retryCnt and enter REQ, so that sieTransReq is high the next cycle.
REQ-018 In REQ, sieTransReq SHALL stay high until sieTransAck=1, after which the FSM enters WAIT and sieTransReq is 0 from the next cycle.
REQ-019 In WAIT, sieTransDone=1 SHALL capture sieStatus into statusReg on that edge and enter UPDATE.
REQ-020 In UPDATE, transDoneInt SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE; the latency from the done pulse to transDoneInt is 1 cycle.
REQ-021 transReq SHALL be ignored in any state other than IDLE.
REQ-022 sieTransDone SHALL be ignored outside WAIT, and sieTransAck SHALL be ignored outside REQ.
REQ-023 clrStatus SHALL zero statusReg; if a capture occurs in the same cycle, the capture SHALL take precedence.
REQ-024 sieTransReq and transBusy SHALL be driven from registered state with no combinational path from the inputs.

Reset
REQ-025 When rst_n=0, the block SHALL immediately and asynchronously force: FSM to IDLE, sieTransReq=0, sieTransType=2'b00, statusReg=8'h00, transBusy=0, transDoneInt=0, retryCnt=0.
REQ-026 A reset asserted mid-transaction SHALL abort the transaction, with no interrupt generated after rst_n is released.

Configuration
REQ-027 With HOST_NAK_RETRY_EN defined, a capture whose NAKRxed bit is 1 while retryCnt<RETRY_LIMIT SHALL enter RETRY instead of UPDATE, with no transDoneInt.
REQ-028 RETRY SHALL last one cycle: it increments retryCnt and then enters REQ, re-issuing the same sieTransType.
REQ-029 A NAK captured while retryCnt==RETRY_LIMIT SHALL go to UPDATE as normal, with NAKRxed=1 in statusReg.
REQ-030 Without HOST_NAK_RETRY_EN, the RETRY state and its counter SHALL not exist, retryCnt SHALL be tied to 0, and a NAK SHALL complete through UPDATE.

Structure
REQ-031 A shared package SHALL hold the transType encodings, the statusReg bit-index constants and the FSM state encoding.
REQ-032 The FSM SHALL be a single module with no sub-module.

Verification
REQ-033 transReq with transType=01 in IDLE -> sieTransReq=1 the next cycle; sieTransAck 3 cycles later -> sieTransReq=0 the following cycle; sieTransDone with sieStatus=8'h40 -> statusReg=8'h40 and a 1-cycle transDoneInt.
REQ-034 clrStatus in the same cycle as sieTransDone with sieStatus=8'h01 -> statusReg=8'h01; clrStatus alone afterwards -> statusReg=8'h00.
REQ-035 A second transReq while in WAIT -> ignored; exactly one transDoneInt results and sieTransType is unchanged.
REQ-036 With the macro defined and RETRY_LIMIT=2, an SIE returning 8'h10 three times -> two re-requests, retryCnt=2, then one transDoneInt with statusReg=8'h10.
REQ-037 rst_n pulled low while in WAIT -> all outputs at reset values immediately; a subsequent sieTransDone produces no transDoneInt.
REQ-038 sieTransDone pulsed while in IDLE -> statusReg unchanged and no transDoneInt.
